// File: rtl/p_addsub_seq.sv
// Multi-cycle packed add/subtract: CHUNK bits per cycle with the inter-chunk carry held
// in a register, lane width selectable from XLEN down to 2 bits.
module p_addsub_seq #(
   parameter int XLEN  = 64,
   parameter int CHUNK = 16,
   parameter int PW_W  = $clog2(XLEN)
) (
   input  logic              g_clk,
   input  logic              g_reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   lhs,
   input  logic [XLEN-1:0]   rhs,
   input  logic [PW_W-1:0]   pw,
   input  logic              sub,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   result,
   output logic [XLEN-1:0]   c_out
);

   localparam int NCHUNK = XLEN / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              carry;
   logic [XLEN-1:0]   lhs_r;
   logic [XLEN-1:0]   rhs_r;
   logic              sub_r;
   logic [PW_W-1:0]   lane_mask_r;
   logic              accept;
   logic [XLEN-1:0]   res_nxt;
   logic [XLEN-1:0]   co_nxt;
   logic              chunk_c;
   logic [PW_W-1:0]   j;
   logic              rm;
   logic              ci;
   logic              c;

   // Lane width is a power of two, so "bit is a lane start" is (index & (lane_w-1)) == 0.
   // Iterating from the top bit down lets the lowest set bit of sel win.
   function automatic logic [PW_W-1:0] decode_mask(input logic [PW_W-1:0] sel);
      logic [PW_W-1:0] m;
      m = PW_W'(XLEN - 1);
      for (int k = PW_W - 1; k >= 0; k--) begin
         if (sel[k]) m = PW_W'((XLEN >> k) - 1);
      end
      return m;
   endfunction

   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      res_nxt = result;
      co_nxt  = c_out;
      c       = carry;
      j       = '0;
      rm      = 1'b0;
      ci      = 1'b0;
      for (int i = 0; i < CHUNK; i++) begin
         j  = PW_W'(int'(cnt) * CHUNK + i);
         rm = rhs_r[j] ^ sub_r;
         ci = ((j & lane_mask_r) == '0) ? sub_r : c;
         res_nxt[j] = lhs_r[j] ^ rm ^ ci;
         c  = (lhs_r[j] & rm) | (ci & (lhs_r[j] ^ rm));
         co_nxt[j] = c;
      end
      chunk_c = c;
   end

   // Operand capture; only meaningful after an accept, so it carries no reset.
   always_ff @(posedge g_clk) begin
      if (accept) begin
         lhs_r       <= lhs;
         rhs_r       <= rhs;
         sub_r       <= sub;
         lane_mask_r <= decode_mask(pw);
      end
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         c_out     <= '0;
         cnt       <= '0;
         carry     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= BUSY;
                  cnt   <= '0;
                  carry <= sub;
               end
            end
            BUSY: begin
               result <= res_nxt;
               c_out  <= co_nxt;
               carry  <= chunk_c;
               if (cnt == CNT_W'(NCHUNK - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     state <= BUSY;
                     cnt   <= '0;
                     carry <= sub;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_p_addsub_seq.sv
// Directed bench for p_addsub_seq (XLEN=64, CHUNK=16): vector table plus handshake
// and mid-operation reset sequences.
module tb_p_addsub_seq;

   localparam int XLEN  = 64;
   localparam int CHUNK = 16;
   localparam int PW_W  = 6;

   logic              g_clk = 1'b0;
   logic              g_reset;
   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   lhs;
   logic [XLEN-1:0]   rhs;
   logic [PW_W-1:0]   pw;
   logic              sub;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   result;
   logic [XLEN-1:0]   c_out;

   p_addsub_seq #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
      .g_clk(g_clk), .g_reset(g_reset), .in_valid(in_valid), .in_ready(in_ready),
      .lhs(lhs), .rhs(rhs), .pw(pw), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .c_out(c_out)
   );

   always #5 g_clk = ~g_clk;

   typedef struct {
      string            name;
      logic [XLEN-1:0]  lhs;
      logic [XLEN-1:0]  rhs;
      logic [PW_W-1:0]  pw;
      logic             sub;
      logic [XLEN-1:0]  res;
      logic [XLEN-1:0]  cout;
   } vec_t;

   vec_t tbl [10];
   int   n_vec = 0;
   int   n_bad = 0;
   int   lat;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input vec_t v);
      lhs      = v.lhs;
      rhs      = v.rhs;
      pw       = v.pw;
      sub      = v.sub;
      in_valid = 1'b1;
   endtask

   // Call with an op presented; the next edge must accept it. Operands are then
   // scrambled and in_valid held high while busy, which must have no effect.
   task automatic wait_result(input string name, output int l);
      @(posedge g_clk); #1;
      out_ready = 1'b0;
      lhs = ~lhs;
      rhs = ~rhs;
      pw  = 6'b000001;
      sub = ~sub;
      chk({name, " busy in_ready"}, 64'(in_ready), 64'd0);
      l = 0;
      while (!out_valid && l < 20) begin
         @(posedge g_clk); #1;
         l++;
      end
      in_valid = 1'b0;
   endtask

   task automatic check_vec(input vec_t v, input int l);
      chk({v.name, " latency"}, 64'(l), 64'd4);
      chk({v.name, " result"}, result, v.res);
      chk({v.name, " c_out"}, c_out, v.cout);
   endtask

   task automatic release_out(input string name);
      out_ready = 1'b1;
      @(posedge g_clk); #1;
      out_ready = 1'b0;
      chk({name, " out_valid drop"}, 64'(out_valid), 64'd0);
      chk({name, " idle in_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      tbl[0] = '{"full_add",   64'h00000000_FFFFFFFF, 64'h1, 6'b000001, 1'b0,
                 64'h00000001_00000000, 64'h00000000_FFFFFFFF};
      tbl[1] = '{"lane8_add",  64'hFFFFFFFF_FFFFFFFF, 64'h01010101_01010101, 6'b001000, 1'b0,
                 64'h0, 64'hFFFFFFFF_FFFFFFFF};
      tbl[2] = '{"lane16_sub", 64'h0, 64'h00010001_00010001, 6'b000100, 1'b1,
                 64'hFFFFFFFF_FFFFFFFF, 64'h0};
      tbl[3] = '{"lane2_sub",  64'h55555555_55555555, 64'hAAAAAAAA_AAAAAAAA, 6'b100000, 1'b1,
                 64'hFFFFFFFF_FFFFFFFF, 64'h55555555_55555555};
      tbl[4] = '{"full_sub",   64'h5, 64'h3, 6'b000001, 1'b1,
                 64'h2, 64'hFFFFFFFF_FFFFFFFD};
      tbl[5] = '{"lane32_add", 64'h00000000_FFFFFFFF, 64'h1, 6'b000010, 1'b0,
                 64'h0, 64'h00000000_FFFFFFFF};
      tbl[6] = '{"pw_lowest",  64'hFFFFFFFF_FFFFFFFF, 64'h01010101_01010101, 6'b101000, 1'b0,
                 64'h0, 64'hFFFFFFFF_FFFFFFFF};
      tbl[7] = '{"pw_zero",    64'hFF, 64'h1, 6'b000000, 1'b0,
                 64'h100, 64'hFF};
      tbl[8] = '{"lane4_add",  64'h11111111_1111111F, 64'h1, 6'b010000, 1'b0,
                 64'h11111111_11111110, 64'hF};
      tbl[9] = '{"full_sub_chain", 64'h00010000_00000000, 64'h1, 6'b000001, 1'b1,
                 64'h0000FFFF_FFFFFFFF, 64'hFFFF0000_00000000};

      g_reset   = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      lhs = '0; rhs = '0; pw = '0; sub = 1'b0;
      repeat (2) @(posedge g_clk);
      #1 g_reset = 1'b0;
      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset result", result, 64'h0);
      chk("reset c_out", c_out, 64'h0);

      for (int i = 0; i < 10; i++) begin
         issue(tbl[i]);
         wait_result(tbl[i].name, lat);
         check_vec(tbl[i], lat);
         release_out(tbl[i].name);
      end

      // Back-pressure in DONE, then back-to-back accept on the releasing edge.
      issue(tbl[0]);
      wait_result("hs_first", lat);
      check_vec(tbl[0], lat);
      issue(tbl[2]);
      for (int i = 0; i < 5; i++) begin
         @(posedge g_clk); #1;
         chk("hs hold result", result, tbl[0].res);
         chk("hs hold c_out", c_out, tbl[0].cout);
         chk("hs hold in_ready", 64'(in_ready), 64'd0);
         chk("hs hold out_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      #1 chk("hs release in_ready", 64'(in_ready), 64'd1);
      wait_result("hs_second", lat);
      check_vec(tbl[2], lat);
      release_out("hs_second");

      // Reset while the counter sits at 2.
      issue(tbl[0]);
      repeat (3) begin
         @(posedge g_clk); #1;
      end
      in_valid = 1'b0;
      #2 g_reset = 1'b1;
      #1;
      chk("rst busy in_ready", 64'(in_ready), 64'd1);
      chk("rst busy out_valid", 64'(out_valid), 64'd0);
      chk("rst busy result", result, 64'h0);
      chk("rst busy c_out", c_out, 64'h0);
      #1 g_reset = 1'b0;
      @(posedge g_clk); #1;
      issue(tbl[9]);
      wait_result("post_reset", lat);
      check_vec(tbl[9], lat);
      release_out("post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
